// File: rtl/full_hash_core.sv
// rtl/full_hash_core.sv - 32-bit FNV-1a hash core with byte handshake (optional FULL_HASH_FAST_MUL_EN)
`timescale 1ns/1ps

module full_hash_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  Byte,
    input  logic        End_of_File,
    input  logic        F_dr,
    output logic [0:31] R_h,
    output logic        F_rtr,
    output logic        H_ready
);

    localparam logic [31:0] FNV_OFFSET = 32'h811C9DC5;
    localparam logic [31:0] FNV_PRIME  = 32'h01000193;

    typedef enum logic [1:0] {
        READY = 2'd0,
        MUL   = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] h;
    logic        armed;
    logic        capture;
    logic        finish;
    logic        mul_done;
    logic [31:0] h_mixed;

    // End_of_File wins over a byte capture landing in the same cycle
    always_comb begin
        finish  = (state == READY) && End_of_File;
        capture = (state == READY) && armed && !F_dr && !End_of_File;
        h_mixed = h ^ {24'd0, Byte};
    end

`ifdef FULL_HASH_FAST_MUL_EN
    // single-cycle low-word multiply: MUL lasts exactly one cycle
    always_comb begin
        mul_done = 1'b1;
    end
`else
    logic [4:0]  bit_idx;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] acc_sum;

    // partial product for the current prime bit; mcand is pre-shifted to that bit weight
    always_comb begin
        acc_sum  = acc + (FNV_PRIME[bit_idx] ? mcand : 32'd0);
        mul_done = (bit_idx == 5'd31);
    end

    // shift-add multiplier walking all 32 bits of the prime, one per MUL cycle
    always_ff @(posedge clk) begin
        if (rst_n) begin
            bit_idx <= 5'd0;
            acc     <= 32'd0;
            mcand   <= 32'd0;
        end else if (capture) begin
            bit_idx <= 5'd0;
            acc     <= 32'd0;
            mcand   <= h_mixed;
        end else if (state == MUL) begin
            bit_idx <= bit_idx + 5'd1;
            acc     <= acc_sum;
            mcand   <= {mcand[30:0], 1'b0};
        end
    end
`endif

    // state register; rst_n is active-high despite its name
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= READY;
        end else begin
            state <= state_next;
        end
    end

    // next-state and handshake outputs, decoded from the current state
    always_comb begin
        state_next = state;
        F_rtr      = 1'b0;
        H_ready    = 1'b0;
        case (state)
            READY: begin
                F_rtr = 1'b1;
                if (finish) begin
                    state_next = DONE;
                end else if (capture) begin
                    state_next = MUL;
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_next = READY;
                end
            end
            DONE: begin
                H_ready = 1'b1;
                if (start) begin
                    state_next = READY;
                end
            end
            default: begin
                state_next = READY;
            end
        endcase
    end

    // hash state, arming flag and result register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            h     <= FNV_OFFSET;
            armed <= 1'b0;
            R_h   <= 32'd0;
        end else begin
            case (state)
                READY: begin
                    if (finish) begin
                        R_h   <= h;
                        armed <= 1'b0;
                    end else if (capture) begin
                        h     <= h_mixed;
                        armed <= 1'b0;
                    end else if (F_dr) begin
                        armed <= 1'b1;
                    end
                end
                MUL: begin
`ifdef FULL_HASH_FAST_MUL_EN
                    h <= h * FNV_PRIME;
`else
                    if (mul_done) begin
                        h <= acc_sum;
                    end
`endif
                end
                DONE: begin
                    if (start) begin
                        h     <= FNV_OFFSET;
                        armed <= 1'b0;
                    end
                end
                default: begin
                    armed <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_full_hash_core.sv
// tb/tb_full_hash_core.sv - self-checking bench for full_hash_core against an FNV-1a reference
`timescale 1ns/1ps

module tb_full_hash_core;

`ifdef FULL_HASH_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 32;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  Byte;
    logic        End_of_File;
    logic        F_dr;
    logic [0:31] R_h;
    logic        F_rtr;
    logic        H_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    full_hash_core dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .Byte        (Byte),
        .End_of_File (End_of_File),
        .F_dr        (F_dr),
        .R_h         (R_h),
        .F_rtr       (F_rtr),
        .H_ready     (H_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fnv1a(input logic [7:0] msg[$]);
        logic [31:0] acc;
        acc = 32'h811C9DC5;
        foreach (msg[i]) begin
            acc = (acc ^ {24'd0, msg[i]}) * 32'h01000193;
        end
        return acc;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        start = 1'b0;
        F_dr = 1'b0;
        End_of_File = 1'b0;
        Byte = 8'h00;
        step();
        step();
        rst_n = 1'b0;
        check_eq("rst_r_h", R_h, 32'd0);
        check_eq("rst_h_ready", {31'd0, H_ready}, 32'd0);
        check_eq("rst_f_rtr", {31'd0, F_rtr}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit poke_start);
        int guard;
        int low;
        guard = 0;
        while (F_rtr !== 1'b1 && guard < 100) begin
            step();
            guard++;
        end
        check_eq("rtr_before_byte", {31'd0, F_rtr}, 32'd1);
        for (int i = 0; i < gap; i++) begin
            Byte  = 8'($urandom);
            F_dr  = 1'b0;
            start = ($urandom_range(0, 7) == 0);
            step();
            start = 1'b0;
            check_eq("rtr_idle", {31'd0, F_rtr}, 32'd1);
        end
        Byte = b;
        F_dr = 1'b1;
        step();
        F_dr = 1'b0;
        step();
        Byte = 8'($urandom);
        low = 0;
        while (F_rtr === 1'b0 && low < 100) begin
            low++;
            if (poke_start && low == 1) start = 1'b1;
            step();
            start = 1'b0;
        end
        check_eq("mul_lat", low, MUL_LAT);
    endtask

    task automatic finish_msg(input logic [31:0] exp, input int hold);
        logic [31:0] held;
        End_of_File = 1'b1;
        step();
        End_of_File = 1'b0;
        check_eq("done_h_ready", {31'd0, H_ready}, 32'd1);
        check_eq("done_f_rtr", {31'd0, F_rtr}, 32'd0);
        check_eq("done_r_h", R_h, exp);
        held = exp;
        for (int i = 0; i < hold; i++) begin
            Byte        = 8'($urandom);
            F_dr        = 1'($urandom);
            End_of_File = 1'($urandom);
            step();
            check_eq("hold_r_h", R_h, held);
            check_eq("hold_h_ready", {31'd0, H_ready}, 32'd1);
        end
        F_dr        = 1'b0;
        End_of_File = 1'b0;
        start       = 1'b1;
        step();
        start = 1'b0;
        check_eq("start_h_ready", {31'd0, H_ready}, 32'd0);
        check_eq("start_f_rtr", {31'd0, F_rtr}, 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] msg[$];
        logic [7:0] foobar[$];
        int len;

        foobar = '{8'h66, 8'h6F, 8'h6F, 8'h62, 8'h61, 8'h72};

        do_reset();
        finish_msg(32'h811C9DC5, 2);

        send_byte(8'h61, 0, 1'b0);
        finish_msg(32'hE40C292C, 1);

        foreach (foobar[i]) send_byte(foobar[i], $urandom_range(0, 3), (i == 2));
        finish_msg(32'hBF9CF968, 5);

        for (int i = 0; i < 3; i++) send_byte(foobar[i], 0, 1'b0);
        do_reset();
        foreach (foobar[i]) send_byte(foobar[i], 0, 1'b0);
        finish_msg(32'hBF9CF968, 1);

        send_byte(8'h61, 500, 1'b0);
        finish_msg(32'hE40C292C, 1);

        msg = '{8'h66, 8'h6F, 8'h6F};
        foreach (msg[i]) send_byte(msg[i], 0, 1'b0);
        Byte = 8'h62;
        F_dr = 1'b1;
        step();
        F_dr        = 1'b0;
        End_of_File = 1'b1;
        step();
        End_of_File = 1'b0;
        check_eq("eof_prio_r_h", R_h, fnv1a(msg));
        check_eq("eof_prio_h_ready", {31'd0, H_ready}, 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;

        for (int m = 0; m < 12; m++) begin
            msg.delete();
            len = $urandom_range(0, 10);
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            foreach (msg[i]) send_byte(msg[i], $urandom_range(0, 4), ($urandom_range(0, 3) == 0));
            finish_msg(fnv1a(msg), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
